// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared state type, mode constants and atan table for the CORDIC rotator
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  // Binary angles at 32-bit scale: 2^32 is one full turn.
  localparam logic [31:0] ANGLE_90 = 32'h4000_0000;

  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - atan(2^-i) rounded from the 32-bit table down to WIDTH bits
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [4:0]       index,
  output logic [WIDTH-1:0] angle
);

  localparam logic [31:0] HALF_LSB = 32'd1 << (31 - WIDTH);

  assign angle = WIDTH'((ATAN_TABLE[index] + HALF_LSB) >> (32 - WIDTH));

endmodule

// File: rtl/cordic_rotator.sv
// rtl/cordic_rotator.sv - iterative CORDIC core, rotation and vectoring modes, one micro-rotation per cycle
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  localparam int XW = WIDTH + 2;
  localparam logic signed [XW-1:0]    SAT_MAX = XW'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0]    SAT_MIN = -SAT_MAX;
  localparam logic signed [WIDTH-1:0] Z_90    = $signed(ANGLE_90[31 -: WIDTH]);
  localparam logic [4:0]              LAST    = 5'(ITERS);

  state_t state, state_next;
  logic                    mode_q;
  logic signed [XW-1:0]    x_q, y_q, x_pre, y_pre, x_rot, y_rot, x_shr, y_shr;
  logic signed [WIDTH-1:0] z_q, z_pre, z_rot;
  logic [4:0]              iter_q;
  logic [WIDTH-1:0]        atan_i;
  logic                    dir_pos;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX) return WIDTH'(SAT_MAX);
    else if (v < SAT_MIN) return WIDTH'(SAT_MIN);
    else return WIDTH'(v);
  endfunction

  cordic_atan_rom #(.WIDTH(WIDTH)) u_atan_rom (
    .index (iter_q),
    .angle (atan_i)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = PRE;
      end
      PRE:  state_next = ITER;
      ITER: if (iter_q == LAST) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Quadrant fold so the micro-rotations only ever cover +/-99.9 degrees.
  always_comb begin
    x_pre = x_q;
    y_pre = y_q;
    z_pre = z_q;
    if (mode_q == MODE_ROTATE) begin
      if (z_q[WIDTH-1:WIDTH-2] == 2'b01) begin
        x_pre = -y_q;
        y_pre = x_q;
        z_pre = z_q - Z_90;
      end else if (z_q[WIDTH-1:WIDTH-2] == 2'b10) begin
        x_pre = y_q;
        y_pre = -x_q;
        z_pre = z_q + Z_90;
      end
    end else if (x_q[XW-1]) begin
      if (!y_q[XW-1]) begin
        x_pre = y_q;
        y_pre = -x_q;
        z_pre = z_q + Z_90;
      end else begin
        x_pre = -y_q;
        y_pre = x_q;
        z_pre = z_q - Z_90;
      end
    end
  end

  always_comb begin
    dir_pos = (mode_q == MODE_ROTATE) ? !z_q[WIDTH-1] : y_q[XW-1];
    x_shr   = x_q >>> iter_q;
    y_shr   = y_q >>> iter_q;
    if (dir_pos) begin
      x_rot = x_q - y_shr;
      y_rot = y_q + x_shr;
      z_rot = z_q - $signed(atan_i);
    end else begin
      x_rot = x_q + y_shr;
      y_rot = y_q - x_shr;
      z_rot = z_q + $signed(atan_i);
    end
  end

  // The ITER pass with iter_q == ITERS only registers the saturated results.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      mode_q <= MODE_ROTATE;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      iter_q <= '0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q <= mode;
            x_q    <= XW'(x_in);
            y_q    <= XW'(y_in);
            z_q    <= z_in;
          end
        end
        PRE: begin
          x_q    <= x_pre;
          y_q    <= y_pre;
          z_q    <= z_pre;
          iter_q <= '0;
        end
        ITER: begin
          if (iter_q == LAST) begin
            x_out <= sat(x_q);
            y_out <= sat(y_q);
            z_out <= z_q;
          end else begin
            x_q    <= x_rot;
            y_q    <= y_rot;
            z_q    <= z_rot;
            iter_q <= iter_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// tb/tb_cordic_rotator.sv - randomized self-checking bench for cordic_rotator against a trigonometric model
module tb_cordic_rotator;

  localparam int  WIDTH  = 16;
  localparam int  ITERS  = 14;
  localparam int  FULL   = 65536;
  localparam int  MAXV   = 32767;
  localparam int  TOL_XY = 32;
  localparam int  TOL_Z  = 32;
  localparam real PI     = 3.14159265358979;

  logic clock     = 1'b0;
  logic reset_n   = 1'b0;
  logic in_valid  = 1'b0;
  logic mode      = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [WIDTH-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic signed [WIDTH-1:0] x_out, y_out, z_out;

  int  errors = 0;
  int  checks = 0;
  real kgain;
  bit  rand_ready = 1'b0;

  typedef struct {
    int x;
    int y;
    int z;
    bit m;
    bit sx;
    bit sy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  cordic_rotator #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  function automatic int wrap_ang(input int a);
    int w;
    w = a & (FULL - 1);
    if (w >= FULL / 2) w -= FULL;
    return w;
  endfunction

  function automatic int clamp(input real v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return int'(v);
  endfunction

  function automatic bit beyond(input real v);
    return (v > real'(MAXV + TOL_XY)) || (v < -real'(MAXV + TOL_XY));
  endfunction

  // Ideal CORDIC result: gain-scaled rotation by z, or gain-scaled magnitude plus atan2 angle.
  function automatic exp_t model(input bit m, input int xi, input int yi, input int zi);
    exp_t e;
    real  th, xr, yr;
    e.m = m;
    if (!m) begin
      th  = 2.0 * PI * real'(zi) / real'(FULL);
      xr  = kgain * (real'(xi) * $cos(th) - real'(yi) * $sin(th));
      yr  = kgain * (real'(xi) * $sin(th) + real'(yi) * $cos(th));
      e.z = 0;
    end else begin
      xr  = kgain * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
      yr  = 0.0;
      e.z = wrap_ang(zi + int'($atan2(real'(yi), real'(xi)) * real'(FULL) / (2.0 * PI)));
    end
    e.x  = clamp(xr);
    e.y  = clamp(yr);
    e.sx = beyond(xr);
    e.sy = beyond(yr);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int want, input int tol);
    int d;
    d = act - want;
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, want, tol);
    end
  endtask

  task automatic check_ang(input string name, input int act, input int want, input int tol);
    int d;
    d = wrap_ang(act - want);
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (mod 2^16)", name, act, want, tol);
    end
  endtask

  // Every cycle a result is presented it must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: got 1, expected 0");
        end else begin
          e = exp_q[0];
          check("model_x", x_out, e.x, e.sx ? 0 : TOL_XY);
          check("model_y", y_out, e.y, e.sy ? 0 : TOL_XY);
          check_ang("model_z", z_out, e.z, e.m ? TOL_Z : 8);
          check("busy_in_ready", in_ready, 0, 0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_op(input bit m, input int xi, input int yi, input int zi);
    int n;
    n = 0;
    @(posedge clock);
    #1;
    mode     = m;
    x_in     = WIDTH'(xi);
    y_in     = WIDTH'(yi);
    z_in     = WIDTH'(zi);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(m, xi, yi, zi));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    mode     = 1'($urandom);
    x_in     = WIDTH'($urandom);
    y_in     = WIDTH'($urandom);
    z_in     = WIDTH'($urandom);
  endtask

  task automatic run_op(input bit m, input int xi, input int yi, input int zi, input int stall,
                        output int lat, output int rx, output int ry, output int rz);
    out_ready = 1'b0;
    start_op(m, xi, yi, zi);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clock);
      #1;
      lat++;
    end
    rx = x_out;
    ry = y_out;
    rz = z_out;
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got out_valid=0, expected 1 within 64 cycles");
      return;
    end
    for (int k = 0; k < stall; k++) begin
      @(posedge clock);
      #1;
      check("hold_x", x_out, rx, 0);
      check("hold_y", y_out, ry, 0);
      check("hold_z", z_out, rz, 0);
      check("hold_out_valid", out_valid, 1, 0);
      check("hold_in_ready", in_ready, 0, 0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1, 0);
    check("release_out_valid", out_valid, 0, 0);
  endtask

  initial begin
    int   lat, rx, ry, rz, n, xi, yi, zi;
    bit   m;
    exp_t p;

    kgain = 1.0;
    for (int i = 0; i < ITERS; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));

    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", in_ready, 1, 0);
    check("reset_out_valid", out_valid, 0, 0);
    check("reset_x_out", x_out, 0, 0);
    check("reset_y_out", y_out, 0, 0);
    check("reset_z_out", z_out, 0, 0);
    reset_n = 1'b1;

    p = model(1'b0, 19898, 0, 'h2000);
    check("pin_rot45_x", p.x, 23170, 4);
    check("pin_rot45_y", p.y, 23170, 4);
    p = model(1'b1, 12288, 12288, 0);
    check("pin_vec45_x", p.x, 28618, 2);
    check_ang("pin_vec45_z", p.z, 8192, 1);
    p = model(1'b1, -12288, 0, 0);
    check_ang("pin_vec180_z", p.z, 32768, 1);

    run_op(1'b0, 'h4DBA, 0, 'h2000, 0, lat, rx, ry, rz);
    check("latency", lat, ITERS + 2, 0);
    check("rot45_x", rx, 'h5A82, 4);
    check("rot45_y", ry, 'h5A82, 4);
    check_ang("rot45_z", rz, 0, 4);

    run_op(1'b0, 'h4DBA, 0, 'h8000, 0, lat, rx, ry, rz);
    check("rot180_x", rx, -'h7FFF, 4);
    check("rot180_y", ry, 0, 4);
    run_op(1'b0, 'h4DBA, 0, 'h4000, 0, lat, rx, ry, rz);
    check("rot90_x", rx, 0, 4);
    check("rot90_y", ry, 'h7FFF, 4);

    run_op(1'b1, 'h3000, 'h3000, 0, 0, lat, rx, ry, rz);
    check_ang("vec45_z", rz, 'h2000, 4);
    check("vec45_y", ry, 0, 4);
    check("vec45_x", rx, 28618, 8);
    run_op(1'b1, -'h3000, 0, 0, 0, lat, rx, ry, rz);
    check_ang("vec180_z", rz, 'h8000, 2);
    check("vec180_x", rx, 20236, 8);

    run_op(1'b0, 'h4DBA, 0, 'h1000, 5, lat, rx, ry, rz);
    run_op(1'b0, 'h4DBA, 0, -'h1555, 0, lat, rx, ry, rz);
    check("back_to_back_latency", lat, ITERS + 2, 0);

    out_ready = 1'b0;
    start_op(1'b0, 'h4DBA, 0, 'h2000);
    repeat (6) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("abort_in_ready", in_ready, 1, 0);
    check("abort_out_valid", out_valid, 0, 0);
    check("abort_x_out", x_out, 0, 0);
    check("abort_y_out", y_out, 0, 0);
    check("abort_z_out", z_out, 0, 0);
    reset_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    run_op(1'b0, 'h4DBA, 0, 'h2000, 0, lat, rx, ry, rz);
    check("after_abort_x", rx, 'h5A82, 4);
    check("after_abort_y", ry, 'h5A82, 4);

    rand_ready = 1'b1;
    repeat (40) begin
      m = 1'($urandom_range(0, 1));
      xi = int'($urandom_range(0, 40000)) - 20000;
      yi = int'($urandom_range(0, 40000)) - 20000;
      zi = int'($urandom_range(0, 65535)) - 32768;
      n = 0;
      while (m && (xi * xi + yi * yi < 8000 * 8000) && n < 100) begin
        xi = int'($urandom_range(0, 40000)) - 20000;
        yi = int'($urandom_range(0, 40000)) - 20000;
        n++;
      end
      if (m && (xi * xi + yi * yi < 8000 * 8000)) xi = 12000;
      start_op(m, xi, yi, zi);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
    end
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
